// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single write port of a DEPTH x DATA_WIDTH register file among
// NUM_REQ requesters. Arbitration is round-robin with a valid/ready handshake
// per requester. A clear sequencer can take over the port and write zero to
// every address, one address per cycle.
//
// Ports:
//   clk        : clock, all logic on the rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : per-requester write request
//   req_ready  : per-requester accept (combinational, at most one high)
//   req_addr   : flattened addresses, requester i at [i*ADDR_BITS +: ADDR_BITS]
//   req_data   : flattened data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   clr_req    : start a clear sequence (level sampled in RUN)
//   busy       : high while the clear sequence owns the port
//   clr_done   : one-cycle pulse with the final clear write
//   addr_err   : one-cycle pulse when an accepted write addressed >= DEPTH
//   rf_wen     : register file write enable (registered)
//   rf_wraddr  : register file write address (registered, holds when idle)
//   rf_datain  : register file write data (registered, holds when idle)
//   grant_id   : requester owning the current rf_wen cycle
//
// Build option:
//   REGFILE_WRITE_ARBITER_CLEAR_ON_RESET_EN - when defined, the arbiter leaves
//   reset in CLEAR, so the file is zeroed before any request is accepted.

module regfile_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = $clog2(DEPTH),
  parameter int ID_BITS    = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic                            clr_req,
  output logic                            busy,
  output logic                            clr_done,
  output logic                            addr_err,
  output logic                            rf_wen,
  output logic [ADDR_BITS-1:0]            rf_wraddr,
  output logic [DATA_WIDTH-1:0]           rf_datain,
  output logic [ID_BITS-1:0]              grant_id
);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

`ifdef REGFILE_WRITE_ARBITER_CLEAR_ON_RESET_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = RUN;
`endif

  state_t                  state;
  state_t                  state_next;
  logic [ID_BITS-1:0]      rr_ptr;
  logic [ID_BITS-1:0]      rr_ptr_next;
  logic [ADDR_BITS-1:0]    clr_cnt;
  logic                    clr_last;
  logic                    win_found;
  logic [ID_BITS-1:0]      win_id;
  logic [ADDR_BITS-1:0]    win_addr;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    win_oor;
  logic                    grant;

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    int                 idx_i;
    logic [ID_BITS-1:0] idx;
    idx_i     = 0;
    idx       = '0;
    win_found = 1'b0;
    win_id    = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_i = int'(rr_ptr) + k;
      if (idx_i >= NUM_REQ) begin
        idx_i = idx_i - NUM_REQ;
      end
      idx = ID_BITS'(idx_i);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Select the winner's address and data from the flattened buses.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_BITS'(i)) begin
        win_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
        win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // An out-of-range address can only occur when DEPTH is not a power of two.
  if ((1 << ADDR_BITS) == DEPTH) begin : g_pow2_depth
    assign win_oor = 1'b0;
  end else begin : g_npow2_depth
    localparam logic [ADDR_BITS:0] DEPTH_EXT = (ADDR_BITS+1)'(DEPTH);
    assign win_oor = ({1'b0, win_addr} >= DEPTH_EXT);
  end

  // A pending clear request blocks every handshake in the same cycle.
  assign grant       = (state == RUN) && !clr_req && win_found;
  assign req_ready   = grant ? (NUM_REQ'(1) << win_id) : '0;
  assign rr_ptr_next = (win_id == ID_BITS'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
  assign clr_last    = (clr_cnt == ADDR_BITS'(DEPTH-1));

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (clr_req)  state_next = CLEAR;
      CLEAR:   if (clr_last) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      clr_cnt   <= '0;
      rf_wen    <= 1'b0;
      rf_wraddr <= '0;
      rf_datain <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      clr_done  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      rf_wen   <= 1'b0;
      clr_done <= 1'b0;
      addr_err <= 1'b0;
      // busy drops together with the final clear write.
      busy     <= (state_next == CLEAR);
      if (state == CLEAR) begin
        rf_wen    <= 1'b1;
        rf_wraddr <= clr_cnt;
        rf_datain <= '0;
        if (clr_last) begin
          clr_done <= 1'b1;
          clr_cnt  <= '0;
        end else begin
          clr_cnt  <= clr_cnt + 1'b1;
        end
      end else if (grant) begin
        rr_ptr   <= rr_ptr_next;
        grant_id <= win_id;
        // A bad address completes the handshake but never reaches the file.
        if (win_oor) begin
          addr_err <= 1'b1;
        end else begin
          rf_wen    <= 1'b1;
          rf_wraddr <= win_addr;
          rf_datain <= win_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  typedef struct {
    int          cyc;
    logic        err;
    logic        clr;
    logic        done;
    logic [1:0]  id;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: DEPTH=32
  logic         rst_a;
  logic [3:0]   a_valid, a_ready;
  logic [19:0]  a_addr;
  logic [127:0] a_data;
  logic         a_clr, a_busy, a_done, a_err, a_wen;
  logic [4:0]   a_wraddr;
  logic [31:0]  a_datain;
  logic [1:0]   a_gid;

  // DUT B: DEPTH=24
  logic         rst_b;
  logic [3:0]   b_valid, b_ready;
  logic [19:0]  b_addr;
  logic [127:0] b_data;
  logic         b_clr, b_busy, b_done, b_err, b_wen;
  logic [4:0]   b_wraddr;
  logic [31:0]  b_datain;
  logic [1:0]   b_gid;

  regfile_write_arbiter #(.NUM_REQ(4), .DEPTH(32), .DATA_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(a_valid), .req_ready(a_ready),
    .req_addr(a_addr), .req_data(a_data), .clr_req(a_clr), .busy(a_busy),
    .clr_done(a_done), .addr_err(a_err), .rf_wen(a_wen), .rf_wraddr(a_wraddr),
    .rf_datain(a_datain), .grant_id(a_gid)
  );

  regfile_write_arbiter #(.NUM_REQ(4), .DEPTH(24), .DATA_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(b_valid), .req_ready(b_ready),
    .req_addr(b_addr), .req_data(b_data), .clr_req(b_clr), .busy(b_busy),
    .clr_done(b_done), .addr_err(b_err), .rf_wen(b_wen), .rf_wraddr(b_wraddr),
    .rf_datain(b_datain), .grant_id(b_gid)
  );

  logic [4:0]  addr_tab [4];
  logic [31:0] data_tab [4];
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitors: pop one expected transaction whenever a DUT presents an output.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_a && (a_wen || a_err)) begin
      if (qa.size() == 0) begin
        chk("a_spurious_output", {a_wen, a_err}, 2'b00);
      end else begin
        e = qa.pop_front();
        chk("a_out_cycle", cyc, e.cyc);
        chk("a_wen", a_wen, !e.err);
        chk("a_addr_err", a_err, e.err);
        chk("a_clr_done", a_done, e.done);
        if (!e.err) begin
          chk("a_wraddr", a_wraddr, e.addr);
          chk("a_datain", a_datain, e.data);
        end
        if (!e.clr) chk("a_grant_id", a_gid, e.id);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_b && (b_wen || b_err)) begin
      if (qb.size() == 0) begin
        chk("b_spurious_output", {b_wen, b_err}, 2'b00);
      end else begin
        e = qb.pop_front();
        chk("b_out_cycle", cyc, e.cyc);
        chk("b_wen", b_wen, !e.err);
        chk("b_addr_err", b_err, e.err);
        chk("b_clr_done", b_done, e.done);
        if (!e.err) begin
          chk("b_wraddr", b_wraddr, e.addr);
          chk("b_datain", b_datain, e.data);
        end
        if (!e.clr) chk("b_grant_id", b_gid, e.id);
      end
    end
  end

  task automatic push_clear_a(input int first, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e = '{cyc: first + k, err: 1'b0, clr: 1'b1, done: (k == 31),
            id: 2'd0, addr: 5'(k), data: 32'd0};
      qa.push_back(e);
    end
  endtask

  // One cycle on DUT A: drive, check ready/busy, queue the expected write.
  task automatic step(input logic [3:0] v, input logic clr, input int exp_id, input logic exp_busy);
    exp_t e;
    logic [3:0] exp_rdy;
    a_valid = v;
    a_clr   = clr;
    exp_rdy = (exp_id < 0) ? 4'b0000 : 4'(1 << exp_id);
    @(negedge clk);
    chk("a_ready", a_ready, exp_rdy);
    chk("a_busy", a_busy, exp_busy);
    if (exp_id >= 0) begin
      e = '{cyc: cyc + 1, err: 1'b0, clr: 1'b0, done: 1'b0,
            id: 2'(exp_id), addr: addr_tab[exp_id], data: data_tab[exp_id]};
      qa.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic [3:0] v, input int exp_id, input logic exp_err,
                        input logic [4:0] ad, input logic [31:0] dt);
    exp_t e;
    logic [3:0] exp_rdy;
    b_valid       = v;
    b_addr[9:5]   = ad;
    b_data[63:32] = dt;
    exp_rdy = (exp_id < 0) ? 4'b0000 : 4'(1 << exp_id);
    @(negedge clk);
    chk("b_ready", b_ready, exp_rdy);
    if (exp_id >= 0) begin
      e = '{cyc: cyc + 1, err: exp_err, clr: 1'b0, done: 1'b0,
            id: 2'(exp_id), addr: ad, data: dt};
      qb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic post_reset_a();
`ifdef REGFILE_WRITE_ARBITER_CLEAR_ON_RESET_EN
    push_clear_a(cyc + 1, 32);
    step(4'b0000, 1'b0, -1, 1'b0);
    for (int j = 1; j < 32; j++) step(4'b0000, 1'b0, -1, 1'b1);
`endif
  endtask

  task automatic post_reset_b();
`ifdef REGFILE_WRITE_ARBITER_CLEAR_ON_RESET_EN
    exp_t e;
    for (int k = 0; k < 24; k++) begin
      e = '{cyc: cyc + 1 + k, err: 1'b0, clr: 1'b1, done: (k == 23),
            id: 2'd0, addr: 5'(k), data: 32'd0};
      qb.push_back(e);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_valid = '0; a_clr = 1'b0; b_valid = '0; b_clr = 1'b0;
    addr_tab = '{5'd3, 5'd17, 5'd9, 5'd30};
    data_tab = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    for (int i = 0; i < 4; i++) begin
      a_addr[i*5 +: 5]   = addr_tab[i];
      a_data[i*32 +: 32] = data_tab[i];
    end
    b_addr = '0;
    b_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_wen", a_wen, 0);
    chk("rst_wraddr", a_wraddr, 0);
    chk("rst_datain", a_datain, 0);
    chk("rst_grant_id", a_gid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_clr_done", a_done, 0);
    chk("rst_addr_err", a_err, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    post_reset_b();
    post_reset_a();

    // All requesters valid: strict rotation 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, i % 4, 1'b0);

    // Single requesters, then wrap check: pointer sits at 2
    step(4'b0100, 1'b0, 2, 1'b0);
    step(4'b0010, 1'b0, 1, 1'b0);
    step(4'b1111, 1'b0, 2, 1'b0);
    step(4'b0000, 1'b0, -1, 1'b0);

    // Requester 0 drops valid while requester 3 is granted
    step(4'b1001, 1'b0, 3, 1'b0);
    step(4'b0000, 1'b0, -1, 1'b0);

    // Clear with requesters 0 and 3 pending
    push_clear_a(cyc + 2, 32);
    step(4'b1001, 1'b1, -1, 1'b0);
    for (int j = 1; j <= 32; j++) step(4'b1001, 1'b0, -1, 1'b1);
    step(4'b1001, 1'b0, 0, 1'b0);
    step(4'b1000, 1'b0, 3, 1'b0);
    step(4'b0000, 1'b0, -1, 1'b0);

    // Reset in the middle of a clear (clr_cnt=10)
    step(4'b0010, 1'b0, 1, 1'b0);
    push_clear_a(cyc + 2, 10);
    step(4'b1111, 1'b1, -1, 1'b0);
    for (int j = 1; j <= 10; j++) step(4'b0000, 1'b0, -1, 1'b1);
    @(negedge clk);
    #2;
    rst_a = 1'b1;
    #1;
    chk("midclr_wen", a_wen, 0);
    chk("midclr_wraddr", a_wraddr, 0);
    chk("midclr_grant_id", a_gid, 0);
    chk("midclr_busy", a_busy, 0);
    chk("midclr_clr_done", a_done, 0);
    chk("midclr_addr_err", a_err, 0);
    chk("midclr_queue_drained", qa.size(), 0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    post_reset_a();
    step(4'b1111, 1'b0, 0, 1'b0);
    step(4'b0000, 1'b0, -1, 1'b0);

    // DEPTH=24: out-of-range write, then a normal write
    step_b(4'b0010, 1, 1'b1, 5'd30, 32'hDEAD_BEEF);
    step_b(4'b0010, 1, 1'b0, 5'd5, 32'hCAFE_0005);
    step_b(4'b0000, -1, 1'b0, 5'd0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
